// File: rtl/int_seq_pkg.sv
// Shared types and constants for the 6502 interrupt sequencer: sequence kinds,
// step numbers, stack-push selectors and vector offsets.
package int_seq_pkg;

    typedef enum logic [1:0] {
        KIND_RES = 2'd0,
        KIND_NMI = 2'd1,
        KIND_IRQ = 2'd2,
        KIND_BRK = 2'd3
    } int_kind_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEQ  = 1'b1
    } seq_state_e;

    localparam logic [2:0] STEP_DUMMY = 3'd0;
    localparam logic [2:0] STEP_PCH   = 3'd1;
    localparam logic [2:0] STEP_PCL   = 3'd2;
    localparam logic [2:0] STEP_P     = 3'd3;
    localparam logic [2:0] STEP_VECL  = 3'd4;
    localparam logic [2:0] STEP_VECH  = 3'd5;
    localparam logic [2:0] STEP_LAST  = 3'd6;

    localparam logic [1:0] SEL_PCH = 2'b00;
    localparam logic [1:0] SEL_PCL = 2'b01;
    localparam logic [1:0] SEL_P   = 2'b10;

    localparam logic [15:0] VOFS_NMI = 16'd0;
    localparam logic [15:0] VOFS_RES = 16'd2;
    localparam logic [15:0] VOFS_IRQ = 16'd4;

    // BRK shares the IRQ vector.
    function automatic logic [15:0] vec_offset(input int_kind_e kind);
        logic [15:0] ofs;
        case (kind)
            KIND_NMI: ofs = VOFS_NMI;
            KIND_RES: ofs = VOFS_RES;
            default:  ofs = VOFS_IRQ;
        endcase
        return ofs;
    endfunction

endpackage

// File: rtl/interrupt_sequencer_if.sv
// Interrupt pins, boundary/stall strobes and sequence control outputs of the
// interrupt sequencer; slave = sequencer side, master = CPU core side.
interface interrupt_sequencer_if;
    logic        n_NMI;
    logic        n_IRQ;
    logic        n_ready;
    logic        T_END;
    logic        BRK_OP;
    logic        I_FLAG;

    logic        INT_ACTIVE;
    logic [2:0]  SEQ_STEP;
    logic        PUSH_EN;
    logic [1:0]  PUSH_SEL;
    logic        B_OUT;
    logic        SET_I;
    logic        VEC_RD;
    logic [15:0] VEC_ADDR;
    logic        NMI_PENDING;

    modport slave (
        input  n_NMI, n_IRQ, n_ready, T_END, BRK_OP, I_FLAG,
        output INT_ACTIVE, SEQ_STEP, PUSH_EN, PUSH_SEL, B_OUT,
               SET_I, VEC_RD, VEC_ADDR, NMI_PENDING
    );

    modport master (
        output n_NMI, n_IRQ, n_ready, T_END, BRK_OP, I_FLAG,
        input  INT_ACTIVE, SEQ_STEP, PUSH_EN, PUSH_SEL, B_OUT,
               SET_I, VEC_RD, VEC_ADDR, NMI_PENDING
    );
endinterface

// File: rtl/int_sync_edge.sv
// Multi-flop synchroniser for an active-low async pin with a registered
// falling-edge detector; flops reset to 1 (pin inactive).
module int_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic async_in,
    output logic sync_out,
    output logic fall
);
    // Fewer than two stages would not be a real synchroniser.
    localparam int STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    logic [STAGES-1:0] chain_reg;
    logic [STAGES-1:0] chain_next;
    logic              prev_reg;

    genvar gi;
    generate
        for (gi = 0; gi < STAGES; gi++) begin : g_stage
            if (gi == 0) begin : g_first
                assign chain_next[gi] = async_in;
            end else begin : g_rest
                assign chain_next[gi] = chain_reg[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chain_reg <= '1;
            prev_reg  <= 1'b1;
        end else begin
            chain_reg <= chain_next;
            prev_reg  <= chain_reg[STAGES-1];
        end
    end

    assign sync_out = chain_reg[STAGES-1];
    assign fall     = prev_reg & ~chain_reg[STAGES-1];

endmodule

// File: rtl/interrupt_sequencer.sv
// 6502 interrupt/reset/BRK sequencer: arbitrates RES > NMI > IRQ > BRK at
// instruction boundaries and walks the 7-step push/vector sequence.
// Optional build macro INT_NMI_HIJACK_EN lets a pending NMI take over an
// IRQ/BRK sequence at the step-3 to step-4 transition.
module interrupt_sequencer
    import int_seq_pkg::*;
#(
    parameter int          SYNC_STAGES = 2,
    parameter logic [15:0] VEC_BASE    = 16'hFFFA
) (
    input  logic                  PHI0,
    input  logic                  n_RES,
    interrupt_sequencer_if.slave  bus
);

    logic nmi_sync_unused;
    logic nmi_fall;
    logic irq_sync;
    logic irq_fall_unused;

    int_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_nmi_sync (
        .clk      (PHI0),
        .rst_n    (n_RES),
        .async_in (bus.n_NMI),
        .sync_out (nmi_sync_unused),
        .fall     (nmi_fall)
    );

    int_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_irq_sync (
        .clk      (PHI0),
        .rst_n    (n_RES),
        .async_in (bus.n_IRQ),
        .sync_out (irq_sync),
        .fall     (irq_fall_unused)
    );

    seq_state_e state_reg, state_next;
    logic [2:0] step_reg, step_next;
    int_kind_e  kind_reg, kind_next;
    logic       nmi_pend_reg, nmi_pend_next;
    logic       res_pend_reg, res_pend_next;

    logic        int_active;
    logic        push_en;
    logic [1:0]  push_sel;
    logic        b_out;
    logic        set_i;
    logic        vec_rd;
    logic [15:0] vec_addr;
    logic [15:0] vec_lo;
    logic        advance;

    assign advance = ~bus.n_ready;
    assign vec_lo  = VEC_BASE + vec_offset(kind_reg);

    always_ff @(posedge PHI0 or negedge n_RES) begin
        if (!n_RES) begin
            state_reg    <= ST_IDLE;
            step_reg     <= STEP_DUMMY;
            kind_reg     <= KIND_RES;
            nmi_pend_reg <= 1'b0;
            res_pend_reg <= 1'b1;
        end else begin
            state_reg    <= state_next;
            step_reg     <= step_next;
            kind_reg     <= kind_next;
            nmi_pend_reg <= nmi_pend_next;
            res_pend_reg <= res_pend_next;
        end
    end

    always_comb begin
        state_next    = state_reg;
        step_next     = step_reg;
        kind_next     = kind_reg;
        nmi_pend_next = nmi_pend_reg;
        res_pend_next = res_pend_reg;

        int_active = 1'b0;
        push_en    = 1'b0;
        push_sel   = SEL_PCH;
        b_out      = 1'b0;
        set_i      = 1'b0;
        vec_rd     = 1'b0;
        vec_addr   = 16'h0000;

        case (state_reg)
            ST_IDLE: begin
                // A pending reset starts without waiting for an instruction boundary.
                if (advance && (res_pend_reg || bus.T_END)) begin
                    if (res_pend_reg) begin
                        state_next = ST_SEQ;
                        step_next  = STEP_DUMMY;
                        kind_next  = KIND_RES;
                    end else if (nmi_pend_reg) begin
                        state_next = ST_SEQ;
                        step_next  = STEP_DUMMY;
                        kind_next  = KIND_NMI;
                    end else if (!irq_sync && !bus.I_FLAG) begin
                        state_next = ST_SEQ;
                        step_next  = STEP_DUMMY;
                        kind_next  = KIND_IRQ;
                    end else if (bus.BRK_OP) begin
                        state_next = ST_SEQ;
                        step_next  = STEP_DUMMY;
                        kind_next  = KIND_BRK;
                    end
                end
            end

            ST_SEQ: begin
                int_active = 1'b1;
                case (step_reg)
                    STEP_PCH: begin
                        push_en  = (kind_reg != KIND_RES);
                        push_sel = SEL_PCH;
                    end
                    STEP_PCL: begin
                        push_en  = (kind_reg != KIND_RES);
                        push_sel = SEL_PCL;
                    end
                    STEP_P: begin
                        push_en  = (kind_reg != KIND_RES);
                        push_sel = SEL_P;
                        b_out    = (kind_reg == KIND_BRK);
                    end
                    STEP_VECL: begin
                        vec_rd   = 1'b1;
                        vec_addr = vec_lo;
                        set_i    = 1'b1;
                    end
                    STEP_VECH: begin
                        vec_rd   = 1'b1;
                        vec_addr = vec_lo + 16'd1;
                    end
                    default: ;
                endcase

                if (advance) begin
                    if (step_reg == STEP_LAST) begin
                        state_next = ST_IDLE;
                        step_next  = STEP_DUMMY;
                        if (kind_reg == KIND_RES) begin
                            res_pend_next = 1'b0;
                        end
                    end else begin
                        step_next = step_reg + 3'd1;
                    end
`ifdef INT_NMI_HIJACK_EN
                    // The P byte already went out with the original B value;
                    // only the vector fetch switches to NMI.
                    if (step_reg == STEP_P && nmi_pend_reg &&
                        (kind_reg == KIND_IRQ || kind_reg == KIND_BRK)) begin
                        kind_next = KIND_NMI;
                    end
`endif
                    if (step_reg == STEP_VECH && kind_reg == KIND_NMI) begin
                        nmi_pend_next = 1'b0;
                    end
                end
            end

            default: begin
                state_next = ST_IDLE;
                step_next  = STEP_DUMMY;
            end
        endcase

        // A fresh edge wins over a same-cycle clear so it is never lost.
        if (nmi_fall) begin
            nmi_pend_next = 1'b1;
        end
    end

    assign bus.INT_ACTIVE  = int_active;
    assign bus.SEQ_STEP    = (state_reg == ST_SEQ) ? step_reg : 3'd0;
    assign bus.PUSH_EN     = push_en;
    assign bus.PUSH_SEL    = push_sel;
    assign bus.B_OUT       = b_out;
    assign bus.SET_I       = set_i;
    assign bus.VEC_RD      = vec_rd;
    assign bus.VEC_ADDR    = vec_addr;
    assign bus.NMI_PENDING = nmi_pend_reg;

endmodule
